// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter merging N_MST read-request sources onto one AXI3 read port.
// One transaction outstanding; beats are steered combinationally to the granted master.
module axi_rd_arbiter #(
    parameter int unsigned N_MST  = 3,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_MST-1:0]        m_ar_valid,
    output logic [N_MST-1:0]        m_ar_ready,
    input  logic [N_MST*ADDR_W-1:0] m_ar_addr,
    input  logic [N_MST*4-1:0]      m_ar_len,
    input  logic [N_MST*3-1:0]      m_ar_size,
    output logic [N_MST-1:0]        m_r_valid,
    input  logic [N_MST-1:0]        m_r_ready,
    output logic [DATA_W-1:0]       m_r_data,
    output logic                    m_r_last,
    output logic [ID_W-1:0]         arid,
    output logic [ADDR_W-1:0]       araddr,
    output logic [3:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_W-1:0]         rid,
    input  logic [DATA_W-1:0]       rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic                    err
);

    localparam int unsigned IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e            state_q, state_d;
    idx_t              rr_ptr_q, rr_ptr_d;
    idx_t              gnt_q, gnt_d;
    logic [ID_W-1:0]   arid_q, arid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [3:0]        arlen_q, arlen_d;
    logic [2:0]        arsize_q, arsize_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] addr_arr [N_MST];
    logic [3:0]        len_arr  [N_MST];
    logic [2:0]        size_arr [N_MST];

    logic        hit;
    idx_t        hit_idx;
    logic        beat_fire;
    logic        unused_rresp;

    assign unused_rresp = ^rresp;

    for (genvar i = 0; i < N_MST; i++) begin : g_unpack
        assign addr_arr[i] = m_ar_addr[i*ADDR_W +: ADDR_W];
        assign len_arr[i]  = m_ar_len[i*4 +: 4];
        assign size_arr[i] = m_ar_size[i*3 +: 3];
    end

    // First requester at or after rr_ptr, wrapping at N_MST.
    always_comb begin
        int unsigned cand;
        hit     = 1'b0;
        hit_idx = '0;
        cand    = 0;
        for (int unsigned k = 0; k < N_MST; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= N_MST) begin
                cand = cand - N_MST;
            end
            if (!hit && m_ar_valid[idx_t'(cand)]) begin
                hit     = 1'b1;
                hit_idx = idx_t'(cand);
            end
        end
    end

    assign beat_fire = (state_q == StData) && rvalid && m_r_ready[gnt_q];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        arid_d     = arid_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arsize_d   = arsize_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        m_ar_ready = '0;
        m_r_valid  = '0;
        rready     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    m_ar_ready[hit_idx] = 1'b1;
                    gnt_d    = hit_idx;
                    arid_d   = ID_W'(hit_idx);
                    araddr_d = addr_arr[hit_idx];
                    arlen_d  = len_arr[hit_idx];
                    arsize_d = size_arr[hit_idx];
                    state_d  = StAddr;
                end
            end
            StAddr: begin
                if (arready) begin
                    beat_cnt_d = '0;
                    state_d    = StData;
                end
            end
            StData: begin
                m_r_valid[gnt_q] = rvalid;
                rready           = m_r_ready[gnt_q];
                if (beat_fire) begin
                    if (beat_cnt_q != 4'hF) begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end
                    if (rid != arid_q) begin
                        err_d = 1'b1;
                    end
                    // rlast must coincide exactly with the final counted beat.
                    if (rlast != (beat_cnt_q == arlen_q)) begin
                        err_d = 1'b1;
                    end
                    if (rlast) begin
                        rr_ptr_d = (gnt_q == idx_t'(N_MST - 1)) ? '0 : gnt_q + idx_t'(1);
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            arid_q     <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            arid_q     <= arid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arsize_q   <= arsize_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    assign arvalid  = (state_q == StAddr);
    assign arid     = arid_q;
    assign araddr   = araddr_q;
    assign arlen    = arlen_q;
    assign arsize   = arsize_q;
    assign arburst  = 2'b01;
    assign m_r_data = rdata;
    assign m_r_last = rlast;
    assign err      = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: table of single transactions plus hand-written
// sequences for mid-burst reset and 8-master pointer wrap.
module tb_axi_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic [95:0] m_ar_addr;
    logic [11:0] m_ar_len;
    logic [8:0]  m_ar_size;
    logic [31:0] m_r_data;
    logic        m_r_last;
    logic [3:0]  arid, arlen, rid;
    logic [31:0] araddr, rdata;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic        arvalid, arready, rlast, rvalid, rready, err;

    logic [7:0]   v8, rdy8, rv8, rr8;
    logic [255:0] addr8;
    logic [31:0]  len8, data8, rdata8;
    logic [23:0]  size8;
    logic         last8, arvalid8, arready8, rlast8, rvalid8, rready8, err8;
    logic [3:0]   arid8, arlen8, rid8;
    logic [31:0]  araddr8;
    logic [2:0]   arsize8;
    logic [1:0]   arburst8;

    int total = 0;
    int bad   = 0;

    axi_rd_arbiter u_dut (
        .clock(clock), .reset(reset),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_last(m_r_last),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .err(err)
    );

    axi_rd_arbiter #(.N_MST(8)) u_dut8 (
        .clock(clock), .reset(reset),
        .m_ar_valid(v8), .m_ar_ready(rdy8), .m_ar_addr(addr8),
        .m_ar_len(len8), .m_ar_size(size8),
        .m_r_valid(rv8), .m_r_ready(rr8), .m_r_data(data8), .m_r_last(last8),
        .arid(arid8), .araddr(araddr8), .arlen(arlen8), .arsize(arsize8), .arburst(arburst8),
        .arvalid(arvalid8), .arready(arready8),
        .rid(rid8), .rdata(rdata8), .rresp(2'b00), .rlast(rlast8), .rvalid(rvalid8),
        .rready(rready8), .err(err8)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  mask;
        logic [3:0]  len;
        int          exp_g;
        int          ar_wait;
        int          gap;
        int          stall_beat;
        int          last_at;
        logic [3:0]  rid;
        logic [31:0] dbase;
        logic        pre_reset;
        logic        exp_err;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic [2:0] mask, input logic [3:0] len, input int g,
                                input int ar_wait, input int gap, input int stall,
                                input int last_at, input logic [3:0] r_id,
                                input logic [31:0] dbase, input logic pre_rst,
                                input logic exp_err);
        vec_t v;
        v.mask = mask; v.len = len; v.exp_g = g; v.ar_wait = ar_wait; v.gap = gap;
        v.stall_beat = stall; v.last_at = last_at; v.rid = r_id; v.dbase = dbase;
        v.pre_reset = pre_rst; v.exp_err = exp_err;
        return v;
    endfunction

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1FC0_0000 + 32'(i) * 32'h1000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_masters(input logic [3:0] len);
        for (int i = 0; i < 3; i++) begin
            m_ar_addr[i*32 +: 32] = addr_of(i);
            m_ar_len[i*4 +: 4]    = len;
            m_ar_size[i*3 +: 3]   = 3'(i);
        end
    endtask

    task automatic do_txn(input vec_t v, input int idx);
        logic [2:0]  exp_oh;
        logic [31:0] d;
        int          waited;
        exp_oh = 3'b001 << v.exp_g;
        if (v.pre_reset) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
        end
        set_masters(v.len);
        m_ar_valid = v.mask;
        settle();
        waited = 0;
        while (m_ar_ready == 3'b000 && waited < 8) begin
            tick();
            waited++;
        end
        chk($sformatf("v%0d grant", idx), m_ar_ready, exp_oh);
        if (m_ar_ready == 3'b000) begin
            m_ar_valid = '0;
            return;
        end
        tick();
        m_ar_valid = '0;
        settle();
        chk($sformatf("v%0d ar", idx), {arvalid, arid, araddr, arlen, arsize, arburst},
            {1'b1, 4'(v.exp_g), addr_of(v.exp_g), v.len, 3'(v.exp_g), 2'b01});
        for (int w = 0; w < v.ar_wait; w++) begin
            tick();
            chk($sformatf("v%0d ar_hold", idx), {arvalid, arlen, araddr},
                {1'b1, v.len, addr_of(v.exp_g)});
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b <= v.last_at; b++) begin
            for (int gp = 0; gp < v.gap; gp++) begin
                rvalid = 1'b0;
                settle();
                chk($sformatf("v%0d gap", idx), m_r_valid, 3'b000);
                tick();
            end
            d      = v.dbase + 32'(b);
            rvalid = 1'b1;
            rid    = v.rid;
            rdata  = d;
            rlast  = (b == v.last_at);
            if (b == v.stall_beat) begin
                m_r_ready = 3'b000;
                repeat (2) begin
                    settle();
                    chk($sformatf("v%0d stall", idx), {rready, m_r_valid}, {1'b0, exp_oh});
                    tick();
                end
            end
            m_r_ready = 3'b111;
            settle();
            chk($sformatf("v%0d beat%0d", idx, b), {rready, m_r_valid, m_r_last, m_r_data},
                {1'b1, exp_oh, 1'(b == v.last_at), d});
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        settle();
        chk($sformatf("v%0d idle", idx), {arvalid, m_r_valid, rready}, 5'b0);
        chk($sformatf("v%0d err", idx), err, v.exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        m_ar_valid = '0; m_r_ready = 3'b111; m_ar_addr = '0; m_ar_len = '0; m_ar_size = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b10; rlast = 1'b0; rvalid = 1'b0;
        v8 = '0; rr8 = '1; addr8 = '0; len8 = '0; size8 = '0;
        arready8 = 1'b0; rid8 = '0; rdata8 = '0; rlast8 = 1'b0; rvalid8 = 1'b0;

        vecs[0]  = mk(3'b001, 4'd0, 0, 0, 0, -1, 0, 4'd0, 32'hDEADBEEF, 1'b0, 1'b0);
        vecs[1]  = mk(3'b111, 4'd0, 1, 0, 0, -1, 0, 4'd1, 32'h1111_0000, 1'b0, 1'b0);
        vecs[2]  = mk(3'b111, 4'd0, 2, 0, 0, -1, 0, 4'd2, 32'h2222_0000, 1'b0, 1'b0);
        vecs[3]  = mk(3'b111, 4'd0, 0, 1, 0, -1, 0, 4'd0, 32'h3333_0000, 1'b0, 1'b0);
        vecs[4]  = mk(3'b011, 4'd0, 1, 0, 0, -1, 0, 4'd1, 32'h4444_0000, 1'b0, 1'b0);
        vecs[5]  = mk(3'b101, 4'd0, 2, 0, 0, -1, 0, 4'd2, 32'h5555_0000, 1'b0, 1'b0);
        vecs[6]  = mk(3'b010, 4'd3, 1, 5, 1,  2, 3, 4'd1, 32'h6666_0000, 1'b0, 1'b0);
        vecs[7]  = mk(3'b010, 4'd0, 1, 0, 0, -1, 0, 4'd2, 32'h7777_0000, 1'b0, 1'b1);
        vecs[8]  = mk(3'b001, 4'd0, 0, 0, 0, -1, 0, 4'd0, 32'h8888_0000, 1'b0, 1'b1);
        vecs[9]  = mk(3'b100, 4'd3, 2, 0, 0, -1, 2, 4'd2, 32'h9999_0000, 1'b1, 1'b1);
        vecs[10] = mk(3'b001, 4'd0, 0, 0, 0, -1, 0, 4'd0, 32'hAAAA_0000, 1'b0, 1'b1);

        settle();
        chk("reset_ctl", {arvalid, rready, m_ar_ready, m_r_valid, err}, 9'b0);
        chk("reset_ar", {arid, araddr, arlen, arsize, arburst}, {4'h0, 32'h0, 4'h0, 3'h0, 2'b01});
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i], i);
        end

        // Mid-burst reset: m2 granted (pointer at 2), reset after two beats.
        set_masters(4'd3);
        m_ar_valid = 3'b111;
        settle();
        chk("t1 grant", m_ar_ready, 3'b100);
        tick();
        m_ar_valid = '0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            rvalid = 1'b1; rid = 4'd2; rdata = 32'(b); rlast = 1'b0;
            tick();
        end
        rdata = 32'h2;
        reset = 1'b1;
        settle();
        chk("t1 in_reset", {arvalid, rready, m_r_valid, err}, 6'b0);
        tick();
        reset = 1'b0;
        settle();
        chk("t1 no_fwd", {rready, m_r_valid}, 4'b0);
        rvalid = 1'b0;
        m_ar_valid = 3'b111;
        settle();
        chk("t1 ptr0", m_ar_ready, 3'b001);
        m_ar_valid = '0;
        tick();

        for (int i = 7; i < 11; i++) begin
            do_txn(vecs[i], i);
        end

        // 8-master wrap: serve m6 so the pointer lands on 7, then check wrap to m0.
        v8 = 8'h40;
        settle();
        chk("t6 g6", rdy8, 8'h40);
        tick();
        v8 = '0;
        arready8 = 1'b1;
        tick();
        arready8 = 1'b0;
        rvalid8 = 1'b1; rid8 = 4'd6; rlast8 = 1'b1; rdata8 = 32'h6;
        settle();
        chk("t6 beat6", rv8, 8'h40);
        tick();
        rvalid8 = 1'b0; rlast8 = 1'b0;
        v8 = 8'h81;
        settle();
        chk("t6 ptr7", rdy8, 8'h80);
        v8 = 8'h01;
        settle();
        chk("t6 wrap", rdy8, 8'h01);
        tick();
        v8 = '0;
        settle();
        chk("t6 arid", {arvalid8, arid8}, {1'b1, 4'h0});
        arready8 = 1'b1;
        tick();
        arready8 = 1'b0;
        rvalid8 = 1'b1; rid8 = 4'd0; rlast8 = 1'b1;
        settle();
        chk("t6 beat0", rv8, 8'h01);
        tick();
        rvalid8 = 1'b0; rlast8 = 1'b0;
        settle();
        chk("t6 err", {err8, rready8}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
